// File: rtl/fc_frame_stack_if.sv
// ---------------------------------------------------------------------------
// fc_frame_stack_if
// Bundles the request/response signals between the control unit, the
// register file and the call-frame stack.
//
// Signals:
//   save          control -> stack : push request, 1-cycle pulse
//   restore_req   control -> stack : pop request, 1-cycle pulse
//   fc_frame_in   regfile -> stack : frame to push (regfile fcOut)
//   clr_err       control -> stack : synchronous clear of sticky errors
//   fc_frame_out  stack -> regfile : last popped frame (regfile fcIn)
//   restore_valid stack -> regfile : 1-cycle pulse, fc_frame_out is valid
//   busy          stack -> control : pop in progress
//   depth         stack -> control : number of stored frames
//   full / empty  stack -> control : occupancy flags
//   err           stack -> control : sticky {collision, underflow, overflow}
//
// Modports:
//   master : the requesting side (control unit + regfile)
//   slave  : the stack itself
// ---------------------------------------------------------------------------
interface fc_frame_stack_if #(
    parameter int FRAME_W = 240,
    parameter int PTR_W   = 4
) ();

    logic               save;
    logic               restore_req;
    logic [FRAME_W-1:0] fc_frame_in;
    logic               clr_err;
    logic [FRAME_W-1:0] fc_frame_out;
    logic               restore_valid;
    logic               busy;
    logic [PTR_W:0]     depth;
    logic               full;
    logic               empty;
    logic [2:0]         err;

    modport master (
        output save,
        output restore_req,
        output fc_frame_in,
        output clr_err,
        input  fc_frame_out,
        input  restore_valid,
        input  busy,
        input  depth,
        input  full,
        input  empty,
        input  err
    );

    modport slave (
        input  save,
        input  restore_req,
        input  fc_frame_in,
        input  clr_err,
        output fc_frame_out,
        output restore_valid,
        output busy,
        output depth,
        output full,
        output empty,
        output err
    );

endinterface

// File: rtl/fc_frame_stack.sv
// ---------------------------------------------------------------------------
// fc_frame_stack
// Hardware call-frame stack for the register file's function-call
// save/restore path. A save pulse pushes the current 240-bit register frame;
// a restore_req pulse pops the newest frame, drives it on fc_frame_out and
// then pulses restore_valid so the regfile can write it back.
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : asynchronous, active-high reset
//   bus    : fc_frame_stack_if.slave (requests in, frame/status out)
//
// Every output comes straight from a register (or from a compare on the
// stack pointer / state register), so there is no input-to-output path.
// ---------------------------------------------------------------------------
module fc_frame_stack #(
    parameter int FRAME_W = 240,
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    fc_frame_stack_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PTR_W:0] L_DEPTH = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] L_ONE   = {{PTR_W{1'b0}}, 1'b1};

    state_t             r_state;
    logic [PTR_W:0]     r_sp;
    logic [FRAME_W-1:0] r_frameOut;
    logic               r_restoreValid;
    logic [2:0]         r_err;
    logic [FRAME_W-1:0] r_mem [DEPTH];

    logic w_idle;
    logic w_full;
    logic w_empty;
    logic w_pushOk;
    logic w_popOk;
    logic w_overflow;
    logic w_underflow;
    logic w_collision;
    logic [2:0] w_newErr;

    // Occupancy flags come from the stack pointer alone; sp counts stored
    // frames and is guarded so it never wraps past 0 or DEPTH.
    assign w_idle  = (r_state == IDLE);
    assign w_full  = (r_sp == L_DEPTH);
    assign w_empty = (r_sp == '0);

    // Request decode. A pop always wins over a simultaneous save; the save
    // is dropped and flagged as a collision. Anything arriving while a pop
    // is still in flight is also a collision and is otherwise ignored.
    assign w_pushOk    = w_idle & bus.save & ~bus.restore_req & ~w_full;
    assign w_popOk     = w_idle & bus.restore_req & ~w_empty;
    assign w_overflow  = w_idle & bus.save & ~bus.restore_req & w_full;
    assign w_underflow = w_idle & bus.restore_req & w_empty;
    assign w_collision = (w_idle & bus.save & bus.restore_req)
                       | (~w_idle & (bus.save | bus.restore_req));
    assign w_newErr    = {w_collision, w_underflow, w_overflow};

    // Frame storage. The RAM is deliberately not reset so it can map onto
    // block/distributed memory; the write slot is the current sp, which is
    // the first free entry.
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_mem[r_sp[PTR_W-1:0]] <= bus.fc_frame_in;
        end
    end

    // Control FSM. A pop decrements sp on the accepting edge so that in READ
    // sp already points at the newest frame; the frame is registered on the
    // next edge together with restore_valid, which is then held for exactly
    // the DONE cycle. Requests seen in READ or DONE only raise the collision
    // flag. The sticky error bits are cleared by clr_err, but an error
    // detected in the same cycle still lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_sp           <= '0;
            r_frameOut     <= '0;
            r_restoreValid <= 1'b0;
            r_err          <= 3'b000;
        end else begin
            r_err <= (bus.clr_err ? 3'b000 : r_err) | w_newErr;
            case (r_state)
                IDLE: begin
                    r_restoreValid <= 1'b0;
                    if (w_popOk) begin
                        r_sp    <= r_sp - L_ONE;
                        r_state <= READ;
                    end else if (w_pushOk) begin
                        r_sp    <= r_sp + L_ONE;
                    end
                end
                READ: begin
                    r_frameOut     <= r_mem[r_sp[PTR_W-1:0]];
                    r_restoreValid <= 1'b1;
                    r_state        <= DONE;
                end
                DONE: begin
                    r_restoreValid <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    r_restoreValid <= 1'b0;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

    // Output mapping: everything is a register or a compare on one.
    assign bus.fc_frame_out  = r_frameOut;
    assign bus.restore_valid = r_restoreValid;
    assign bus.busy          = ~w_idle;
    assign bus.depth         = r_sp;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.err           = r_err;

endmodule

// File: tb/tb_fc_frame_stack.sv
// ---------------------------------------------------------------------------
// tb_fc_frame_stack
// Directed self-checking bench for fc_frame_stack: push/pop ordering,
// full/empty handling, sticky errors, collisions, reset mid-pop and
// back-to-back traffic.
// ---------------------------------------------------------------------------
module tb_fc_frame_stack;

    localparam int FRAME_W = 240;
    localparam int DEPTH   = 16;
    localparam int PTR_W   = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    int   lastValidCyc;

    fc_frame_stack_if #(.FRAME_W(FRAME_W), .PTR_W(PTR_W)) bus ();

    fc_frame_stack #(.FRAME_W(FRAME_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock and a cycle counter used to measure pop spacing.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Distinct frame pattern for index k.
    function automatic logic [FRAME_W-1:0] mkFrame(input int k);
        logic [9:0] v;
        v = k[9:0];
        return {24{v}};
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of requests, let the DUT sample them, then release.
    task automatic applyStimulus(input logic s, input logic r, input logic c,
                                 input logic [FRAME_W-1:0] f);
        bus.save        = s;
        bus.restore_req = r;
        bus.clr_err     = c;
        bus.fc_frame_in = f;
        @(posedge clk);
        #1;
        bus.save        = 1'b0;
        bus.restore_req = 1'b0;
        bus.clr_err     = 1'b0;
    endtask

    // Issue a pop and follow it through READ and DONE back to IDLE.
    task automatic popAndCheck(input string tag, input logic [FRAME_W-1:0] expFrame,
                               input logic [PTR_W:0] expDepth);
        int lat;
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        lat = 1;
        checkOutput({tag, "_busy"}, 256'(bus.busy), 256'd1);
        while (!bus.restore_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        lastValidCyc = cyc;
        checkOutput({tag, "_lat"}, 256'(lat), 256'd2);
        checkOutput({tag, "_frame"}, 256'(bus.fc_frame_out), 256'(expFrame));
        checkOutput({tag, "_depth"}, 256'(bus.depth), 256'(expDepth));
        @(posedge clk);
        #1;
        checkOutput({tag, "_vdrop"}, 256'(bus.restore_valid), 256'd0);
        checkOutput({tag, "_idle"}, 256'(bus.busy), 256'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [FRAME_W-1:0] f1;
        logic [FRAME_W-1:0] f2;
        int prevCyc;
        logic sawValid;

        checks          = 0;
        failures        = 0;
        cyc             = 0;
        lastValidCyc    = 0;
        bus.save        = 1'b0;
        bus.restore_req = 1'b0;
        bus.clr_err     = 1'b0;
        bus.fc_frame_in = '0;
        f1 = {60{4'h1}};
        f2 = {60{4'h2}};

        // Reset state
        reset = 1'b1;
        #12;
        checkOutput("rst_busy",  256'(bus.busy),          256'd0);
        checkOutput("rst_valid", 256'(bus.restore_valid), 256'd0);
        checkOutput("rst_depth", 256'(bus.depth),         256'd0);
        checkOutput("rst_empty", 256'(bus.empty),         256'd1);
        checkOutput("rst_full",  256'(bus.full),          256'd0);
        checkOutput("rst_err",   256'(bus.err),           256'd0);
        checkOutput("rst_frame", 256'(bus.fc_frame_out),  256'd0);
        reset = 1'b0;

        // Test 1: two pushes, two pops in LIFO order
        applyStimulus(1'b1, 1'b0, 1'b0, f1);
        applyStimulus(1'b1, 1'b0, 1'b0, f2);
        checkOutput("t1_depth", 256'(bus.depth), 256'd2);
        checkOutput("t1_busy",  256'(bus.busy),  256'd0);
        checkOutput("t1_outHeld", 256'(bus.fc_frame_out), 256'd0);
        popAndCheck("t1_popF2", f2, 5'd1);
        popAndCheck("t1_popF1", f1, 5'd0);
        checkOutput("t1_empty", 256'(bus.empty), 256'd1);

        // Test 2: fill, overflow, drain in LIFO order
        for (int k = 1; k <= DEPTH; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, mkFrame(k));
        end
        checkOutput("t2_full",  256'(bus.full),  256'd1);
        checkOutput("t2_depth", 256'(bus.depth), 256'd16);
        applyStimulus(1'b1, 1'b0, 1'b0, mkFrame(999));
        checkOutput("t2_ovfErr",   256'(bus.err),   256'd1);
        checkOutput("t2_ovfDepth", 256'(bus.depth), 256'd16);
        checkOutput("t2_outHeld",  256'(bus.fc_frame_out), 256'(f1));
        for (int i = 0; i < DEPTH; i++) begin
            popAndCheck($sformatf("t2_pop%0d", i), mkFrame(DEPTH - i), 5'(DEPTH - 1 - i));
        end
        checkOutput("t2_empty", 256'(bus.empty), 256'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("t2_clr", 256'(bus.err), 256'd0);

        // Test 3: underflow
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("t3_err",   256'(bus.err),  256'd2);
        checkOutput("t3_busy",  256'(bus.busy), 256'd0);
        sawValid = bus.restore_valid;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            sawValid = sawValid | bus.restore_valid;
        end
        checkOutput("t3_noValid", 256'(sawValid), 256'd0);
        checkOutput("t3_depth",   256'(bus.depth), 256'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("t3_clr", 256'(bus.err), 256'd0);

        // Test 4: simultaneous save+restore, then save (with clr) during READ
        applyStimulus(1'b1, 1'b0, 1'b0, mkFrame(40));
        applyStimulus(1'b1, 1'b1, 1'b0, mkFrame(41));
        checkOutput("t4_busy",  256'(bus.busy),  256'd1);
        checkOutput("t4_depth", 256'(bus.depth), 256'd0);
        checkOutput("t4_err",   256'(bus.err),   256'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, mkFrame(42));
        checkOutput("t4_readErr", 256'(bus.err),           256'd4);
        checkOutput("t4_valid",   256'(bus.restore_valid), 256'd1);
        checkOutput("t4_frame",   256'(bus.fc_frame_out),  256'(mkFrame(40)));
        checkOutput("t4_depthR",  256'(bus.depth),         256'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("t4_depthI", 256'(bus.depth), 256'd0);
        checkOutput("t4_idle",   256'(bus.busy),  256'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("t4_clr", 256'(bus.err), 256'd0);

        // Test 5: reset asserted while in READ
        applyStimulus(1'b1, 1'b0, 1'b0, mkFrame(50));
        applyStimulus(1'b1, 1'b0, 1'b0, mkFrame(51));
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("t5_inRead", 256'(bus.busy), 256'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_busy",  256'(bus.busy),          256'd0);
        checkOutput("t5_valid", 256'(bus.restore_valid), 256'd0);
        checkOutput("t5_depth", 256'(bus.depth),         256'd0);
        checkOutput("t5_frame", 256'(bus.fc_frame_out),  256'd0);
        #2;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, mkFrame(52));
        checkOutput("t5_noValid", 256'(bus.restore_valid), 256'd0);
        checkOutput("t5_depthP",  256'(bus.depth),         256'd1);
        popAndCheck("t5_pop", mkFrame(52), 5'd0);

        // Test 6: back-to-back saves, then pops as fast as busy allows
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, mkFrame(100 + k));
        end
        checkOutput("t6_depth", 256'(bus.depth), 256'd8);
        checkOutput("t6_err",   256'(bus.err),   256'd0);
        prevCyc = 0;
        for (int i = 0; i < 8; i++) begin
            popAndCheck($sformatf("t6_pop%0d", i), mkFrame(107 - i), 5'(7 - i));
            if (i > 0) begin
                checkOutput($sformatf("t6_gap%0d", i), 256'(lastValidCyc - prevCyc), 256'd3);
            end
            prevCyc = lastValidCyc;
        end
        checkOutput("t6_empty", 256'(bus.empty), 256'd1);
        checkOutput("t6_errEnd", 256'(bus.err), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
